// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares a single-port data memory between the CPU
// memory stage (port A) and the loader/debug port (port B), one 3-cycle access at a time.
module dmem_arbiter #(
    parameter int MEM_DEPTH = 101,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic          b_err,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_wr,
    output logic          mem_towrite,
    output logic          mem_toread,
    input  logic [DW-1:0] mem_read
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   last_b;
    logic   own_b;
    logic   own_we;
    logic   own_oor;

    logic          pick_b;
    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_ok;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < AW'(MEM_DEPTH);
    endfunction

    // B wins only when A is idle or when A was the most recent owner.
    always_comb begin
        any_req   = a_req | b_req;
        pick_b    = b_req & (~a_req | ~last_b);
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_ok    = in_range(sel_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            own_b       <= 1'b0;
            own_we      <= 1'b0;
            own_oor     <= 1'b0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            a_err       <= 1'b0;
            b_err       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            mem_ad      <= '0;
            mem_wr      <= '0;
            mem_towrite <= 1'b0;
            mem_toread  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= ACCESS;
                        own_b   <= pick_b;
                        last_b  <= pick_b;
                        own_we  <= sel_we;
                        own_oor <= ~sel_ok;
                        a_gnt   <= ~pick_b;
                        b_gnt   <= pick_b;
                        // Memory controls are set up together with gnt so the
                        // address and strobe change on the same edge.
                        if (sel_ok) begin
                            mem_ad      <= sel_addr;
                            mem_wr      <= sel_we ? sel_wdata : '0;
                            mem_towrite <= sel_we;
                            mem_toread  <= ~sel_we;
                        end
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    a_gnt       <= 1'b0;
                    b_gnt       <= 1'b0;
                    mem_ad      <= '0;
                    mem_wr      <= '0;
                    mem_towrite <= 1'b0;
                    mem_toread  <= 1'b0;
                    a_done      <= ~own_b;
                    b_done      <= own_b;
                    a_err       <= ~own_b & own_oor;
                    b_err       <= own_b & own_oor;
                    if (!own_we) begin
                        if (own_b) b_rdata <= own_oor ? '0 : mem_read;
                        else       a_rdata <= own_oor ? '0 : mem_read;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    a_err  <= 1'b0;
                    b_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, arbitration and reset
// sequences, and randomized dual-port traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 101;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_ad, mem_wr, mem_read;
    logic        mem_towrite, mem_toread;

    dmem_arbiter #(.MEM_DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .mem_ad(mem_ad), .mem_wr(mem_wr), .mem_towrite(mem_towrite),
        .mem_toread(mem_toread), .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [0:DEPTH-1];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] preload(input int i);
        if (i == 2)   return 32'd9;
        if (i == 100) return 32'h77;
        return i * 16 + 7;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= preload(i);
            mem_init <= 1'b1;
        end else if (mem_towrite && mem_ad < DEPTH) begin
            mem[mem_ad[6:0]] <= mem_wr;
        end
    end

    assign mem_read = (mem_ad < DEPTH) ? mem[mem_ad[6:0]] : 32'h0;

    // Transaction-level reference model
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] ref_rdata [2];
    logic        m_last_b;
    logic [31:0] got_rdata;
    logic        got_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last_b = 1'b1;
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
    endtask

    // Present up to two requests at once and follow them until both complete.
    task automatic run_pair(input logic ae, input logic awe, input logic [31:0] aad, input logic [31:0] awd,
                            input logic be, input logic bwe, input logic [31:0] bad, input logic [31:0] bwd);
        logic pend_a, pend_b, exp_b, got, we, ok;
        logic [31:0] addr, wd;
        int cycles, own, oth;
        @(negedge clk);
        a_req = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_req = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        pend_a = ae;
        pend_b = be;
        while (pend_a || pend_b) begin
            exp_b = pend_b && (!pend_a || !m_last_b);
            got = 0;
            cycles = 0;
            while (!got && cycles < 8) begin
                @(posedge clk); #1;
                cycles++;
                if (a_gnt || b_gnt) got = 1;
            end
            if (!got) begin
                check("gnt_timeout", 32'(cycles), 32'd1);
                a_req = 0; b_req = 0;
                return;
            end
            check("gnt_latency", 32'(cycles), 32'd1);
            check("a_gnt", a_gnt, !exp_b);
            check("b_gnt", b_gnt, exp_b);
            m_last_b = exp_b;
            own  = exp_b ? 1 : 0;
            oth  = 1 - own;
            we   = exp_b ? bwe : awe;
            addr = exp_b ? bad : aad;
            wd   = exp_b ? bwd : awd;
            ok   = addr < DEPTH;
            check("mem_toread", mem_toread, ok && !we);
            check("mem_towrite", mem_towrite, ok && we);
            check("mem_ad", mem_ad, ok ? addr : 0);
            check("mem_wr", mem_wr, (ok && we) ? wd : 0);
            check("done_early", a_done | b_done, 0);
            if (exp_b) b_req = 0; else a_req = 0;
            if (ok && we) ref_mem[addr[6:0]] = wd;
            if (!we) ref_rdata[own] = ok ? ref_mem[addr[6:0]] : 0;

            @(posedge clk); #1;
            check("a_done", a_done, !exp_b);
            check("b_done", b_done, exp_b);
            check("own_rdata", exp_b ? b_rdata : a_rdata, ref_rdata[own]);
            check("own_err", exp_b ? b_err : a_err, !ok);
            check("other_rdata", exp_b ? a_rdata : b_rdata, ref_rdata[oth]);
            check("other_err", exp_b ? a_err : b_err, 0);
            check("strobes_resp", {mem_towrite, mem_toread}, 0);
            check("gnt_resp", {a_gnt, b_gnt}, 0);
            got_rdata = exp_b ? b_rdata : a_rdata;
            got_err   = exp_b ? b_err : a_err;

            @(posedge clk); #1;
            check("done_idle", {a_done, b_done, a_err, b_err}, 0);
            check("strobes_idle", {mem_towrite, mem_toread}, 0);
            if (exp_b) pend_b = 0; else pend_a = 0;
        end
    endtask

    typedef struct {
        logic        port_b;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);
        vecs[0]  = '{0, 0, 32'd2,          32'h0,      32'd9,      0};
        vecs[1]  = '{1, 1, 32'd20,         32'h1234,   32'h0,      0};
        vecs[2]  = '{1, 0, 32'd20,         32'h0,      32'h1234,   0};
        vecs[3]  = '{0, 0, 32'd101,        32'h0,      32'h0,      1};
        vecs[4]  = '{0, 1, 32'hFFFF_FFFF,  32'hBAD,    32'h0,      1};
        vecs[5]  = '{0, 1, 32'd5,          32'hABCD,   32'h0,      0};
        vecs[6]  = '{0, 0, 32'd5,          32'h0,      32'hABCD,   0};
        vecs[7]  = '{1, 0, 32'd100,        32'h0,      32'h77,     0};
        vecs[8]  = '{1, 0, 32'd102,        32'h0,      32'h0,      1};
        vecs[9]  = '{1, 1, 32'd100,        32'h55,     32'h0,      0};
        vecs[10] = '{0, 0, 32'd0,          32'h0,      32'd7,      0};
        vecs[11] = '{1, 0, 32'd20,         32'h0,      32'h1234,   0};

        // Reset state
        do_reset();
        check("rst_outputs", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_towrite, mem_toread}, 0);
        check("rst_rdata", a_rdata | b_rdata, 0);
        check("rst_mem_bus", mem_ad | mem_wr, 0);

        // Both ports requesting continuously: A, B, A, B every 3 cycles
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 2;
        b_req = 1; b_we = 0; b_addr = 20;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            check("rr_a_gnt", a_gnt, (k % 3 == 1) && ((k / 3) % 2 == 0));
            check("rr_b_gnt", b_gnt, (k % 3 == 1) && ((k / 3) % 2 == 1));
        end
        a_req = 0; b_req = 0;
        do_reset();

        // Directed single-port table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].port_b)
                run_pair(0, 0, 0, 0, 1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            else
                run_pair(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 0, 0, 0);
            check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
        end
        check("mem100_written", mem[100], 32'h55);
        check("mem20_written", mem[20], 32'h1234);

        // Reset during the ACCESS cycle of a B write
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 30; b_wdata = 32'hDEAD;
        begin
            int cyc = 0;
            while (!b_gnt && cyc < 8) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("rst_b_gnt", b_gnt, 1);
        end
        check("rst_towrite_before", mem_towrite, 1);
        #2 rst = 1;
        #1;
        check("rst_towrite_async", mem_towrite, 0);
        check("rst_mem_ad_async", mem_ad, 0);
        check("rst_b_gnt_async", b_gnt, 0);
        @(posedge clk); #1;
        check("rst_no_done", b_done, 0);
        @(negedge clk);
        rst = 0;
        b_req = 0;
        m_last_b = 1'b1;
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
        @(posedge clk); #1;
        check("rst_no_done_after", {a_done, b_done}, 0);
        check("mem30_untouched", mem[30], ref_mem[30]);
        run_pair(1, 0, 32'd30, 0, 1, 0, 32'd2, 0);
        check("post_rst_a_read", a_rdata, preload(30));

        // Randomized dual-port traffic
        for (int it = 0; it < 40; it++) begin
            logic ae, be, awe, bwe;
            logic [31:0] aad, bad, awd, bwd;
            ae  = 1'($urandom_range(0, 1));
            be  = 1'($urandom_range(0, 1));
            if (!ae && !be) ae = 1;
            awe = 1'($urandom_range(0, 1));
            bwe = 1'($urandom_range(0, 1));
            aad = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 110));
            bad = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 110));
            awd = $urandom;
            bwd = $urandom;
            run_pair(ae, awe, aad, awd, be, bwe, bad, bwd);
        end

        begin
            int bad_words = 0;
            for (int i = 0; i < DEPTH; i++)
                if (mem[i] !== ref_mem[i]) bad_words++;
            check("mem_final_contents", 32'(bad_words), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters.
- Port A is the CPU memory stage; port B is the loader/debug port.
- Round-robin arbitration, one access per 3-cycle transaction.
- All memory control outputs are registered; a write strobe never overlaps an address change.

Parameters:
- MEM_DEPTH, 101: number of valid word addresses (0..MEM_DEPTH-1).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  AW  port A word address.
- a_wdata  in  DW  port A write data.
- a_gnt  out  1  port A request accepted (1-cycle pulse).
- a_done  out  1  port A transaction complete (1-cycle pulse).
- a_rdata  out  DW  port A read data, valid when a_done=1.
- a_err  out  1  port A address out of range, valid when a_done=1.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata, b_err: same as port A, for port B.
- mem_ad  out  AW  memory address.
- mem_wr  out  DW  memory write data.
- mem_towrite  out  1  memory write enable.
- mem_toread  out  1  memory read enable.
- mem_read  in  DW  memory read data, combinational from mem_ad.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset (async): state=IDLE; last_grant=B, so A wins the first tie. All outputs 0, including mem_ad, mem_wr, mem_towrite, mem_toread, gnt, done, rdata, err.
- Reset mid-transaction aborts the transaction immediately. mem_towrite drops asynchronously. No done pulse is issued for the aborted access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, exactly one req: latch that port's we/addr/wdata and owner; pulse its gnt next cycle; go to ACCESS.
- IDLE, both req: grant the port that is not last_grant; update last_grant.
- ACCESS (one cycle), addr < MEM_DEPTH:
  - mem_ad=latched addr.
  - Write: mem_wr=latched wdata, mem_towrite=1.
  - Read: mem_toread=1; capture mem_read into the owner's rdata register at the end of the cycle.
  - Next state: RESP.
- ACCESS, addr >= MEM_DEPTH (unsigned compare on full AW): no strobe; rdata captured as 0; err flag set; next state RESP.
- RESP (one cycle): owner's done=1; err valid. Return to IDLE.
- Strobes: mem_towrite and mem_toread are 1 only in ACCESS, never both. In IDLE/RESP, mem_ad, mem_wr and both strobes are 0.
- Latency: req sampled in IDLE at edge N → gnt high in cycle N+1 (ACCESS) → done high in cycle N+2 (RESP). Back-to-back throughput is one transaction per 3 cycles.
- Requester handshake:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
  - req still high in the IDLE cycle after done counts as a new request.
- The non-owner port's gnt, done and err stay 0 during the transaction.
- rdata holds its last value until the next read completes on that port; it is overwritten with 0 on an out-of-range read.
- A write leaves the port's rdata unchanged.
- err is 0 on every in-range done.

Test Plan:
- Reset, then A read addr 2, memory preloaded with 9 → a_gnt in cycle 1; mem_toread=1, mem_ad=2 in that cycle; a_done=1 with a_rdata=9, a_err=0 next cycle. All B outputs stay 0.
- B write addr 20 data 0x1234, then B read addr 20 → mem_towrite a single cycle with mem_ad=20, mem_wr=0x1234; the second transaction returns b_rdata=0x1234.
- A and B requesting continuously from reset → grants alternate A, B, A, B; each gnt is 3 cycles after the previous one; never two gnts in one cycle.
- A read addr 101 and A write addr 0xFFFFFFFF → no mem strobe; a_done=1, a_err=1, a_rdata=0; memory contents unchanged.
- Assert rst during the ACCESS cycle of a B write → mem_towrite drops without a clock edge; no b_done; after release, the next A request is granted first (last_grant=B).
